// File: rtl/pp_frame_writer.sv
// pp_frame_writer: write-side producer for the 32-bit ping-pong sample FIFO.
// Packs 16-bit samples two per word and frames them as a header, an optional
// timestamp word, then PAYLOAD_WORDS data words. An early stop (enable low)
// ends the frame with a pad word if needed and a trailer. The final word of a
// frame requests a bank flip. Words that arrive while the output queue is
// full are dropped and counted.
// Optional feature macro: PP_FRAME_TIMESTAMP_EN (adds the TS word after each
// header and sets header flags[1]).
module pp_frame_writer #(
  parameter int PAYLOAD_WORDS = 1024,
  parameter int QDEPTH        = 4
) (
  input  logic        wr_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        smp_valid,
  input  logic [15:0] smp_data,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_data,
  output logic        fifo_force_flip,
  output logic [15:0] frame_cnt,
  output logic [15:0] ovf_cnt,
  output logic        busy
);

  localparam int QAW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_WORDS - 1);
`ifdef PP_FRAME_TIMESTAMP_EN
  localparam logic TS_EN = 1'b1;
`else
  localparam logic TS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_TS      = 3'd2,
    S_PAYLOAD = 3'd3,
    S_FLUSH   = 3'd4,
    S_TRAIL   = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_half_valid, w_half_valid_next;
  logic [15:0]     r_half_data,  w_half_data_next;
  logic            r_hold_valid, w_hold_valid_next;
  logic [31:0]     r_hold_data,  w_hold_data_next;
  logic [15:0]     r_word_cnt,   w_word_cnt_next;
  logic            r_drop_flag;
  logic            r_flip_pend;
  logic [15:0]     r_frame_cnt;
  logic [15:0]     r_ovf_cnt;
`ifdef PP_FRAME_TIMESTAMP_EN
  logic [31:0]     r_ts_cnt;
`endif

  // Output queue: entry = {LAST tag, data word}
  logic [32:0]     r_q_mem [QDEPTH];
  logic [QAW-1:0]  r_q_wptr, r_q_rptr;
  logic [QAW:0]    r_q_count;

  logic            w_pack_en, w_pair_done;
  logic [31:0]     w_pair_word;
  logic            w_data_push;
  logic [31:0]     w_data_word;
  logic            w_push, w_push_last, w_push_hdr;
  logic [31:0]     w_push_data;
  logic            w_q_empty, w_q_full, w_accept, w_drop, w_pop;
  logic [32:0]     w_head;

  assign w_q_empty = (r_q_count == '0);
  assign w_q_full  = (r_q_count == (QAW+1)'(QDEPTH));
  assign w_accept  = w_push & ~w_q_full;
  assign w_drop    = w_push & w_q_full;
  assign w_pop     = ~w_q_empty & ~fifo_full;
  assign w_head    = r_q_mem[r_q_rptr];

  assign fifo_wr_en      = w_pop;
  assign fifo_data       = w_q_empty ? 32'h0 : w_head[31:0];
  // A dropped LAST still owes the consumer a flip; it is issued on the first
  // writable cycle the queue is empty so it precedes any later frame's words.
  assign fifo_force_flip = (w_pop & w_head[32]) | (r_flip_pend & w_q_empty & ~fifo_full);
  assign frame_cnt       = r_frame_cnt;
  assign ovf_cnt         = r_ovf_cnt;
  assign busy            = (r_state != S_IDLE) | ~w_q_empty;

  // Packing, push-port arbitration and next-state selection
  always_comb begin
    w_state_next      = r_state;
    w_half_valid_next = r_half_valid;
    w_half_data_next  = r_half_data;
    w_hold_valid_next = r_hold_valid;
    w_hold_data_next  = r_hold_data;
    w_word_cnt_next   = r_word_cnt;
    w_pair_done       = 1'b0;
    w_pair_word       = {smp_data, r_half_data};
    w_data_push       = 1'b0;
    w_data_word       = 32'h0;
    w_push            = 1'b0;
    w_push_last       = 1'b0;
    w_push_hdr        = 1'b0;
    w_push_data       = 32'h0;

    w_pack_en = (r_state == S_HDR) | (r_state == S_TS) | (r_state == S_PAYLOAD);
    if (w_pack_en && smp_valid) begin
      if (r_half_valid) begin
        w_pair_done       = 1'b1;
        w_half_valid_next = 1'b0;
      end else begin
        w_half_valid_next = 1'b1;
        w_half_data_next  = smp_data;
      end
    end

    case (r_state)
      S_IDLE: begin
        w_half_valid_next = 1'b0;
        w_hold_valid_next = 1'b0;
        w_word_cnt_next   = 16'h0;
        if (enable) w_state_next = S_HDR;
      end
      S_HDR: begin
        w_push          = 1'b1;
        w_push_hdr      = 1'b1;
        w_push_data     = {8'hA5, 6'b0, TS_EN, r_drop_flag, r_frame_cnt};
        w_word_cnt_next = 16'h0;
        // Port is taken by the header: park a completed pair
        if (w_pair_done) begin
          w_hold_valid_next = 1'b1;
          w_hold_data_next  = w_pair_word;
        end
        if (!enable)
          w_state_next = (w_hold_valid_next | w_half_valid_next) ? S_FLUSH : S_TRAIL;
        else
`ifdef PP_FRAME_TIMESTAMP_EN
          w_state_next = S_TS;
`else
          w_state_next = S_PAYLOAD;
`endif
      end
`ifdef PP_FRAME_TIMESTAMP_EN
      S_TS: begin
        w_push      = 1'b1;
        w_push_data = r_ts_cnt;
        if (w_pair_done) begin
          w_hold_valid_next = 1'b1;
          w_hold_data_next  = w_pair_word;
        end
        if (!enable)
          w_state_next = (w_hold_valid_next | w_half_valid_next) ? S_FLUSH : S_TRAIL;
        else
          w_state_next = S_PAYLOAD;
      end
`endif
      S_PAYLOAD: begin
        if (r_hold_valid) begin
          w_data_push       = 1'b1;
          w_data_word       = r_hold_data;
          w_hold_valid_next = w_pair_done;
          w_hold_data_next  = w_pair_word;
        end else if (w_pair_done) begin
          w_data_push = 1'b1;
          w_data_word = w_pair_word;
        end
        if (!enable)
          w_state_next = (w_hold_valid_next | w_half_valid_next) ? S_FLUSH : S_TRAIL;
      end
      S_FLUSH: begin
        // Parked pair first, then the lone half sample as a pad word
        if (r_hold_valid) begin
          w_data_push       = 1'b1;
          w_data_word       = r_hold_data;
          w_hold_valid_next = 1'b0;
        end else if (r_half_valid) begin
          w_data_push       = 1'b1;
          w_data_word       = {16'h0, r_half_data};
          w_half_valid_next = 1'b0;
        end
        w_state_next = (w_hold_valid_next | w_half_valid_next) ? S_FLUSH : S_TRAIL;
      end
      S_TRAIL: begin
        w_push       = 1'b1;
        w_push_last  = 1'b1;
        w_push_data  = {8'h5A, 8'h00, r_word_cnt};
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Data words share the port; the PAYLOAD_WORDS-th one closes the frame
    if (w_data_push) begin
      w_push          = 1'b1;
      w_push_data     = w_data_word;
      w_word_cnt_next = r_word_cnt + 16'd1;
      if (r_word_cnt == LAST_IDX) begin
        w_push_last       = 1'b1;
        w_word_cnt_next   = 16'h0;
        w_half_valid_next = 1'b0;
        w_hold_valid_next = 1'b0;
        w_state_next      = (enable && r_state == S_PAYLOAD) ? S_HDR : S_IDLE;
      end
    end
  end

  // Queue storage, one register per entry
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_qmem
    // Capture an accepted push into the entry addressed by the write pointer
    always_ff @(posedge wr_clk) begin
      if (w_accept && r_q_wptr == QAW'(gi))
        r_q_mem[gi] <= {w_push_last, w_push_data};
    end
  end

  // FSM, packer, queue pointers and status counters
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_half_valid <= 1'b0;
      r_half_data  <= 16'h0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= 32'h0;
      r_word_cnt   <= 16'h0;
      r_drop_flag  <= 1'b0;
      r_flip_pend  <= 1'b0;
      r_frame_cnt  <= 16'h0;
      r_ovf_cnt    <= 16'h0;
      r_q_wptr     <= '0;
      r_q_rptr     <= '0;
      r_q_count    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_half_valid <= w_half_valid_next;
      r_half_data  <= w_half_data_next;
      r_hold_valid <= w_hold_valid_next;
      r_hold_data  <= w_hold_data_next;
      r_word_cnt   <= w_word_cnt_next;
      if (w_accept) r_q_wptr <= r_q_wptr + 1'b1;
      if (w_pop)    r_q_rptr <= r_q_rptr + 1'b1;
      r_q_count <= r_q_count + (QAW+1)'(w_accept) - (QAW+1)'(w_pop);
      // Drop flag survives a dropped header so the next header still reports it
      if (w_drop)                      r_drop_flag <= 1'b1;
      else if (w_accept && w_push_hdr) r_drop_flag <= 1'b0;
      if (w_drop && w_push_last)             r_flip_pend <= 1'b1;
      else if (w_q_empty && !fifo_full)      r_flip_pend <= 1'b0;
      // Every header issued consumes a frame number, even if it was dropped
      if (w_push_hdr) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

`ifdef PP_FRAME_TIMESTAMP_EN
  // Free-running timestamp counter
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) r_ts_cnt <= 32'h0;
    else     r_ts_cnt <= r_ts_cnt + 32'd1;
  end
`endif

endmodule
